buffer_stream_reader: RTL

// Mode-1 read engine on the far side of the memory buffer: drives m1_r_en/m1_r_addr to sweep a

---
 rtl/buffer_stream_reader.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/buffer_stream_reader.sv
// Mode-1 read engine: sweeps a bank address range, captures the packed bank word one cycle later
// and streams it to the PE array through a 2-entry FIFO governed by read credits.
module buffer_stream_reader #(
    parameter int WID      = 16,
    parameter int N_BUF    = 8,
    parameter int ADDR_RAM = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic [ADDR_RAM-1:0]     base_addr,
    input  logic [ADDR_RAM:0]       num_words,
    output logic                    busy,
    output logic                    done,
    output logic                    m1_r_en,
    output logic [ADDR_RAM-1:0]     m1_r_addr,
    input  logic [N_BUF*WID-1:0]    m1_rd_bus,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [N_BUF*WID-1:0]    out_data
);

    localparam int BW = N_BUF * WID;
    localparam logic [2:0] FIFO_D = 3'd2;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_FIN   = 2'd3;

    logic [1:0]          state_q, state_d;
    logic [ADDR_RAM-1:0] base_q, base_d;
    logic [ADDR_RAM:0]   num_q, num_d;
    logic [ADDR_RAM:0]   issued_q, issued_d;
    logic [ADDR_RAM:0]   accepted_q, accepted_d;
    logic                inflight_q, inflight_d;
    logic [1:0]          count_q, count_d;
    logic [BW-1:0]       head_q, head_d;
    logic [BW-1:0]       tail_q, tail_d;
    logic                valid_q, busy_q, done_q;

    logic                pop_s, push_s, issue_s, abort_s;
    logic [2:0]          occ_s, cap_s;

    // Handshake decode and credit check; a same-cycle pop frees one extra credit.
    always_comb begin
        abort_s = abort && (state_q != S_IDLE);
        pop_s   = valid_q && out_ready;
        push_s  = inflight_q && !abort_s;
        occ_s   = {1'b0, count_q} + {2'b00, inflight_q};
        cap_s   = FIFO_D + {2'b00, pop_s};
        issue_s = (state_q == S_RUN) && (occ_s < cap_s);
    end

    assign m1_r_en   = issue_s;
    assign m1_r_addr = base_q + issued_q[ADDR_RAM-1:0];
    assign out_valid = valid_q;
    assign out_data  = head_q;
    assign busy      = busy_q;
    assign done      = done_q;

    // Next-state logic for the FIFO, counters and sweep FSM.
    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        num_d      = num_q;
        issued_d   = issued_q + {{ADDR_RAM{1'b0}}, issue_s};
        accepted_d = accepted_q + {{ADDR_RAM{1'b0}}, pop_s};
        inflight_d = issue_s;
        count_d    = count_q;
        head_d     = head_q;
        tail_d     = tail_q;

        case (count_q)
            2'd0: begin
                if (push_s) begin
                    head_d  = m1_rd_bus;
                    count_d = 2'd1;
                end else begin
                    count_d = 2'd0;
                end
            end
            2'd1: begin
                if (push_s && pop_s) begin
                    head_d = m1_rd_bus;
                end else if (push_s) begin
                    tail_d  = m1_rd_bus;
                    count_d = 2'd2;
                end else if (pop_s) begin
                    count_d = 2'd0;
                end else begin
                    count_d = 2'd1;
                end
            end
            2'd2: begin
                if (pop_s) begin
                    head_d = tail_q;
                    if (push_s) begin
                        tail_d = m1_rd_bus;
                    end else begin
                        count_d = 2'd1;
                    end
                end else begin
                    count_d = 2'd2;
                end
            end
            default: count_d = 2'd0;
        endcase

        // Abort discards the FIFO contents and the read still in flight.
        if (abort_s) begin
            state_d    = S_IDLE;
            count_d    = 2'd0;
            inflight_d = 1'b0;
            head_d     = head_q;
            tail_d     = tail_q;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        base_d     = base_addr;
                        num_d      = num_words;
                        issued_d   = {(ADDR_RAM+1){1'b0}};
                        accepted_d = {(ADDR_RAM+1){1'b0}};
                        state_d    = (num_words == {(ADDR_RAM+1){1'b0}}) ? S_FIN : S_RUN;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_RUN: begin
                    if (issue_s && (issued_d == num_q)) begin
                        state_d = S_DRAIN;
                    end else begin
                        state_d = S_RUN;
                    end
                end
                S_DRAIN: begin
                    if (accepted_d == num_q) begin
                        state_d = S_FIN;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end
                S_FIN:   state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State registers; outputs are registered copies of the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            base_q     <= {ADDR_RAM{1'b0}};
            num_q      <= {(ADDR_RAM+1){1'b0}};
            issued_q   <= {(ADDR_RAM+1){1'b0}};
            accepted_q <= {(ADDR_RAM+1){1'b0}};
            inflight_q <= 1'b0;
            count_q    <= 2'd0;
            head_q     <= {BW{1'b0}};
            tail_q     <= {BW{1'b0}};
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            num_q      <= num_d;
            issued_q   <= issued_d;
            accepted_q <= accepted_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            valid_q    <= (count_d != 2'd0);
            busy_q     <= (state_d != S_IDLE);
            done_q     <= (state_d == S_FIN);
        end
    end

endmodule
